data_mem_responder: RTL and testbench

Memory-side responder for the processor's data-access path. It accepts one load or store request at a time over a valid/ready handshake, waits a configurable number of cycles, and performs a byte/half/word/doubleword access on a 64-bit-wide storage array. For loads it returns sign- or zero-extended data; it also flags illegal or misaligned accesses. The processor's memory access stage is the initiator and this block is the responder, replacing the ideal zero-latency data memory for multi-cycle memory timing.

---
 rtl/data_mem_responder_pkg.sv | 29 ++
 rtl/data_mem_responder_mem_lane_align.sv | 43 ++++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: funct3 encodings, FSM states
// and the access-size helper.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // 111 reports 8 bytes here; it is rejected as illegal before it matters.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane steering for one 64-bit storage word: store byte-enables and merged
// write word, plus load extraction with sign/zero extension.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata,
    input  logic [63:0] word,
    output logic [7:0]  byte_en,
    output logic [63:0] wr_word,
    output logic [63:0] ld_data
);

    logic [63:0] wdata_shifted;
    logic [63:0] word_shifted;

    always_comb begin
        case (size_bytes(funct3))
            4'd1:    byte_en = 8'h01 << offset;
            4'd2:    byte_en = 8'h03 << offset;
            4'd4:    byte_en = 8'h0f << offset;
            default: byte_en = 8'hff;
        endcase

        wdata_shifted = wdata << {offset, 3'b000};
        for (int i = 0; i < 8; i++) begin
            wr_word[8*i +: 8] = byte_en[i] ? wdata_shifted[8*i +: 8] : word[8*i +: 8];
        end

        word_shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{56{word_shifted[7]}},  word_shifted[7:0]};
            F3_H:    ld_data = {{48{word_shifted[15]}}, word_shifted[15:0]};
            F3_W:    ld_data = {{32{word_shifted[31]}}, word_shifted[31:0]};
            F3_BU:   ld_data = {56'd0, word_shifted[7:0]};
            F3_HU:   ld_data = {48'd0, word_shifted[15:0]};
            F3_WU:   ld_data = {32'd0, word_shifted[31:0]};
            default: ld_data = word_shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with valid/ready request and response channels.
// Build option MISALIGN_CHECK_EN: reject misaligned accesses instead of aligning them.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state, state_next;
    logic [3:0]    cnt;
    logic          cap_write;
    logic [AW+2:0] cap_addr;
    logic [2:0]    cap_f3;
    logic [63:0]   cap_wdata;
    logic [63:0]   mem [DEPTH_WORDS];

    logic          accept, commit, illegal, err;
    logic          cur_write;
    logic [AW+2:0] cur_addr;
    logic [2:0]    cur_f3, mask, eff_off;
    logic [63:0]   cur_wdata, old_word, wr_word, ld_data;
    logic [7:0]    byte_en;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr[63:AW+3];

    // With zero wait cycles the access commits on the accepting edge, straight from the inputs.
    always_comb begin
        accept    = (state == IDLE) && req_valid;
        commit    = !rst && ((accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1));
        cur_write = (state == IDLE) ? req_write  : cap_write;
        cur_addr  = (state == IDLE) ? req_addr[AW+2:0] : cap_addr;
        cur_f3    = (state == IDLE) ? req_funct3 : cap_f3;
        cur_wdata = (state == IDLE) ? req_wdata  : cap_wdata;
        mask      = 3'(size_bytes(cur_f3) - 4'd1);
        illegal   = (cur_f3 == 3'b111) || (cur_write && cur_f3[2]);
`ifdef MISALIGN_CHECK_EN
        err       = illegal || (|(cur_addr[2:0] & mask));
        eff_off   = cur_addr[2:0];
`else
        err       = illegal;
        eff_off   = cur_addr[2:0] & ~mask;
`endif
        old_word  = mem[cur_addr[AW+2:3]];
    end

    mem_lane_align u_lane (
        .funct3  (cur_f3),
        .offset  (eff_off),
        .wdata   (cur_wdata),
        .word    (old_word),
        .byte_en (byte_en),
        .wr_word (wr_word),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_f3    <= 3'd0;
            cap_wdata <= 64'd0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_write <= req_write;
                cap_addr  <= req_addr[AW+2:0];
                cap_f3    <= req_funct3;
                cap_wdata <= req_wdata;
                cnt       <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_rdata <= (err || cur_write) ? 64'd0 : ld_data;
                rsp_err   <= err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 64'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Storage is deliberately unreset.
    always_ff @(posedge clk) begin
        if (commit && cur_write && !err && (|byte_en)) mem[cur_addr[AW+2:3]] <= wr_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (WAIT_CYCLES = 1).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // Drives one request with rsp_ready high; lat = edges from acceptance to rsp_valid, -1 on timeout.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [2:0] f3,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!rsp_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b1, 64'h10, 3'b011, 64'h1122334455667788, rd, er, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sd_latency got %0d exp 1", lat); end
        n_checks++; if (rd !== 64'd0 || er !== 1'b0) begin n_fail++; $display("FAIL sd_rsp got %h/%b exp 0/0", rd, er); end
        do_req(1'b0, 64'h10, 3'b011, 64'd0, rd, er, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ld_latency got %0d exp 1", lat); end
        n_checks++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_rdata got %h exp 1122334455667788", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b exp 0", er); end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 64'h17, 3'b000, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h11) begin n_fail++; $display("FAIL lb_17 got %h exp 11", rd); end
        do_req(1'b1, 64'h13, 3'b000, 64'hF0, rd, er, lat);
        n_checks++; if (er !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL sb_13 err/lat got %b/%0d exp 0/1", er, lat); end
        do_req(1'b0, 64'h13, 3'b000, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'hFFFFFFFFFFFFFFF0) begin n_fail++; $display("FAIL lb_13 got %h exp fffffffffffffff0", rd); end
        do_req(1'b0, 64'h13, 3'b100, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'hF0) begin n_fail++; $display("FAIL lbu_13 got %h exp f0", rd); end
        do_req(1'b0, 64'h10, 3'b011, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h11223344F0667788) begin n_fail++; $display("FAIL ld_after_sb got %h exp 11223344f0667788", rd); end
        do_req(1'b0, 64'h16, 3'b001, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h1122) begin n_fail++; $display("FAIL lh_16 got %h exp 1122", rd); end
        do_req(1'b0, 64'h14, 3'b010, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h11223344) begin n_fail++; $display("FAIL lw_14 got %h exp 11223344", rd); end
        do_req(1'b0, 64'h10, 3'b010, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'hFFFFFFFFF0667788) begin n_fail++; $display("FAIL lw_10 got %h exp fffffffff0667788", rd); end
        do_req(1'b0, 64'h10, 3'b110, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'hF0667788) begin n_fail++; $display("FAIL lwu_10 got %h exp f0667788", rd); end
        do_req(1'b0, 64'h810, 3'b011, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h11223344F0667788) begin n_fail++; $display("FAIL ld_wrap got %h exp 11223344f0667788", rd); end
    endtask

    task automatic test_misalign();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 64'h12, 3'b010, 64'd0, rd, er, lat);
`ifdef MISALIGN_CHECK_EN
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL lw_12_misalign got %h/%b exp 0/1", rd, er); end
`else
        n_checks++; if (er !== 1'b0 || rd !== 64'hFFFFFFFFF0667788) begin n_fail++; $display("FAIL lw_12_aligned got %h/%b exp fffffffff0667788/0", rd, er); end
`endif
    endtask

    task automatic test_backpressure();
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_funct3 = 3'b011; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!rsp_valid && waited < 40) begin @(posedge clk); #1; waited++; end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_timeout got %b exp 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 64'h11223344F0667788) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b rdy=%b d=%h exp 1/0/11223344f0667788", i, rsp_valid, req_ready, rsp_rdata);
            end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd; logic er; int lat; int waited = 0;
        do_req(1'b1, 64'h20, 3'b010, 64'h0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_funct3 = 3'b010; req_wdata = 64'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_wait got rdy=%b v=%b d=%h e=%b exp 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk); rst = 1'b0;
        do_req(1'b0, 64'h20, 3'b010, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'd0 || er !== 1'b0) begin n_fail++; $display("FAIL lw_20_after_abort got %h/%b exp 0/0", rd, er); end
        // Reset while a store response is pending must keep the committed data.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h28; req_funct3 = 3'b010; req_wdata = 64'h12345678; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!rsp_valid && waited < 40) begin @(posedge clk); #1; waited++; end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || waited !== 1) begin n_fail++; $display("FAIL rst_in_resp got v=%b wait=%0d exp 0/1", rsp_valid, waited); end
        @(negedge clk); rst = 1'b0;
        do_req(1'b0, 64'h28, 3'b010, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h12345678) begin n_fail++; $display("FAIL lw_28_after_rst got %h exp 12345678", rd); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 64'h10, 3'b111, 64'd0, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL ld_f3_111 got %h/%b exp 0/1", rd, er); end
        do_req(1'b1, 64'h10, 3'b110, 64'd0, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL sw_f3_110 got %h/%b exp 0/1", rd, er); end
        do_req(1'b1, 64'h10, 3'b111, 64'd0, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL st_f3_111 got %b exp 1", er); end
        do_req(1'b0, 64'h10, 3'b011, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h11223344F0667788 || er !== 1'b0) begin n_fail++; $display("FAIL ld_after_errors got %h/%b exp 11223344f0667788/0", rd, er); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst = 1'b0;
        test_store_load();
        test_byte_lanes();
        test_misalign();
        test_backpressure();
        test_reset_abort();
        test_errors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
